// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite frame scheduler: packet layout,
// coordinate widths, off-screen packet builder and packet validation.
package sprite_pkg;

    localparam int X_W          = 12;
    localparam int Y_W          = 11;
    localparam int SCREEN_W_DEF = 960;
    localparam int SCREEN_H_DEF = 640;

    typedef struct packed {
        logic [X_W-1:0] box_x;
        logic [Y_W-1:0] box_y;
        logic [X_W-1:0] box_xmax;
        logic [Y_W-1:0] box_ymax;
        logic [X_W-1:0] saber_x;
        logic [Y_W-1:0] saber_y;
    } sprite_pkt_t;

    // Every coordinate parked one past the playfield edge so nothing draws.
    function automatic sprite_pkt_t offscreen_pkt(input logic [X_W-1:0] sw,
                                                  input logic [Y_W-1:0] sh);
        sprite_pkt_t p;
        p.box_x    = sw;
        p.box_y    = sh;
        p.box_xmax = sw;
        p.box_ymax = sh;
        p.saber_x  = sw;
        p.saber_y  = sh;
        return p;
    endfunction

    localparam sprite_pkt_t OFFSCREEN_PKT =
        offscreen_pkt(X_W'(SCREEN_W_DEF), Y_W'(SCREEN_H_DEF));

    function automatic logic pkt_ok(input sprite_pkt_t p,
                                    input logic [X_W-1:0] sw,
                                    input logic [Y_W-1:0] sh);
        return (p.box_xmax >= p.box_x) && (p.box_ymax >= p.box_y) &&
               (p.box_x < sw) && (p.box_xmax < sw) && (p.saber_x < sw) &&
               (p.box_y < sh) && (p.box_ymax < sh) && (p.saber_y < sh);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered grant state; a grant
// can be suppressed for a cycle with i_hold without disturbing the rotation.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_hold,
    output logic [1:0] o_gnt,
    output logic [1:0] o_xfer
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t;

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_grant;
    logic       w_last_grant_nxt;
    logic [1:0] w_cand;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        o_gnt            = 2'b00;
        o_xfer           = 2'b00;
        w_cand           = 2'b00;
        w_state_nxt      = IDLE;
        w_last_grant_nxt = r_last_grant;

        case (r_state)
            GRANT0:  o_gnt = 2'b01;
            GRANT1:  o_gnt = 2'b10;
            default: o_gnt = 2'b00;
        endcase
        if (i_hold) o_gnt = 2'b00;

        o_xfer = i_req & o_gnt;
        if (o_xfer[0])      w_last_grant_nxt = 1'b0;
        else if (o_xfer[1]) w_last_grant_nxt = 1'b1;

        // A requester just served may be presenting a fresh packet next cycle,
        // so it is not re-granted until its valid has been seen again.
        w_cand = i_req & ~o_xfer;
        case (w_cand)
            2'b01:   w_state_nxt = GRANT0;
            2'b10:   w_state_nxt = GRANT1;
            2'b11:   w_state_nxt = w_last_grant_nxt ? GRANT0 : GRANT1;
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Arbitrates player/opponent sprite updates into per-requester shadow
// registers and commits them to the display-facing registers on new frame.
module sprite_frame_scheduler
    import sprite_pkg::*;
#(
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int STALE_FRAMES = 30
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              nf_in,
    input  logic [1:0]        req_valid_in,
    output logic [1:0]        req_ready_out,
    input  sprite_pkt_t [1:0] req_pkt_in,
    output sprite_pkt_t       player_pkt_out,
    output sprite_pkt_t       opponent_pkt_out,
    output logic [1:0]        visible_out,
    output logic [1:0]        stale_out,
    output logic [7:0]        reject_count_out
);

    localparam int               AGE_W   = $clog2(STALE_FRAMES + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STALE_FRAMES);
    localparam logic [X_W-1:0]   SW      = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0]   SH      = Y_W'(SCREEN_H);
    localparam sprite_pkt_t      OFF_PKT =
        (SCREEN_W == SCREEN_W_DEF && SCREEN_H == SCREEN_H_DEF) ?
        OFFSCREEN_PKT : offscreen_pkt(SW, SH);

    logic [1:0] w_xfer;
    logic [1:0] w_ok;
    logic [7:0] r_rej;

    // Ready is a registered grant, masked by nf_in so no packet can land in
    // the same cycle the shadows are committed.
    rr_arbiter2 u_arb (
        .i_clk  (clk_in),
        .i_rst  (rst_in),
        .i_req  (req_valid_in),
        .i_hold (nf_in),
        .o_gnt  (req_ready_out),
        .o_xfer (w_xfer)
    );

    assign w_ok = {pkt_ok(req_pkt_in[1], SW, SH), pkt_ok(req_pkt_in[0], SW, SH)};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            sprite_pkt_t      r_shadow;
            sprite_pkt_t      r_active;
            logic             r_dirty;
            logic             r_stale;
            logic [AGE_W-1:0] r_age;
            logic [AGE_W-1:0] w_age_inc;

            assign w_age_inc = (r_age >= AGE_MAX) ? AGE_MAX : r_age + AGE_W'(1);

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    r_shadow <= OFF_PKT;
                    r_active <= OFF_PKT;
                    r_dirty  <= 1'b0;
                    r_stale  <= 1'b1;
                    r_age    <= AGE_MAX;
                end else if (nf_in) begin
                    if (r_dirty) begin
                        r_active <= r_shadow;
                        r_age    <= '0;
                        r_dirty  <= 1'b0;
                        r_stale  <= 1'b0;
                    end else begin
                        r_age   <= w_age_inc;
                        r_stale <= (w_age_inc >= AGE_MAX);
                        if (w_age_inc >= AGE_MAX) r_active <= OFF_PKT;
                    end
                end else if (w_xfer[gi] && w_ok[gi]) begin
                    r_shadow <= req_pkt_in[gi];
                    r_dirty  <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rej <= 8'd0;
        end else if (|(w_xfer & ~w_ok) && (r_rej != 8'hFF)) begin
            r_rej <= r_rej + 8'd1;
        end
    end

    assign player_pkt_out   = g_req[0].r_active;
    assign opponent_pkt_out = g_req[1].r_active;
    assign stale_out        = {g_req[1].r_stale, g_req[0].r_stale};
    assign visible_out      = ~stale_out;
    assign reject_count_out = r_rej;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Directed bench for sprite_frame_scheduler with a per-cycle frame-level model.
`timescale 1ns/1ps
module tb_sprite_frame_scheduler;
    import sprite_pkg::*;

    localparam sprite_pkt_t OFFP = '{12'd960, 11'd640, 12'd960, 11'd640, 12'd960, 11'd640};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              nf  = 1'b0;
    logic [1:0]        vld = 2'b00;
    sprite_pkt_t [1:0] pkts;
    logic [1:0]        rdy, vis, stl;
    sprite_pkt_t       ppkt, opkt;
    logic [7:0]        rej;

    int n_tests = 0;
    int n_fail  = 0;

    sprite_frame_scheduler dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .nf_in            (nf),
        .req_valid_in     (vld),
        .req_ready_out    (rdy),
        .req_pkt_in       (pkts),
        .player_pkt_out   (ppkt),
        .opponent_pkt_out (opkt),
        .visible_out      (vis),
        .stale_out        (stl),
        .reject_count_out (rej)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic sprite_pkt_t mk(input int bx, input int by, input int bxm,
                                       input int bym, input int sx, input int sy);
        sprite_pkt_t p;
        p.box_x    = 12'(bx);
        p.box_y    = 11'(by);
        p.box_xmax = 12'(bxm);
        p.box_ymax = 11'(bym);
        p.saber_x  = 12'(sx);
        p.saber_y  = 11'(sy);
        return p;
    endfunction

    function automatic bit good(input sprite_pkt_t p);
        int bx, by, bxm, bym, sx, sy;
        bx = int'(p.box_x);    by = int'(p.box_y);
        bxm = int'(p.box_xmax); bym = int'(p.box_ymax);
        sx = int'(p.saber_x);  sy = int'(p.saber_y);
        if (bxm < bx || bym < by) return 1'b0;
        if (bx >= 960 || bxm >= 960 || sx >= 960) return 1'b0;
        if (by >= 640 || bym >= 640 || sy >= 640) return 1'b0;
        return 1'b1;
    endfunction

    // Frame-level model: what the display must show, given the packets accepted.
    sprite_pkt_t m_act [2];
    sprite_pkt_t m_sh  [2];
    bit          m_new [2];
    int          m_age [2];
    int          m_rej = 0;
    bit          live  = 1'b0;
    logic [1:0]  prev_vld  = 2'b00;
    logic [1:0]  prev_xfer = 2'b00;

    always @(negedge clk) begin
        if (live) begin
            chk("player_pkt",   69'(ppkt), 69'(m_act[0]));
            chk("opponent_pkt", 69'(opkt), 69'(m_act[1]));
            chk("stale",   69'(stl), 69'({m_age[1] >= 30, m_age[0] >= 30}));
            chk("visible", 69'(vis), 69'({m_age[1] < 30, m_age[0] < 30}));
            chk("reject_count", 69'(rej), 69'(m_rej));
            chk("ready_onehot", 69'(rdy[0] & rdy[1]), 69'(0));
            chk("ready_after_valid", 69'(rdy & ~(prev_vld & ~prev_xfer)), 69'(0));
            if (nf) chk("ready_during_nf", 69'(rdy), 69'(0));
        end
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = OFFP;
                m_sh[i]  = OFFP;
                m_new[i] = 1'b0;
                m_age[i] = 30;
            end
            m_rej = 0;
            live  = 1'b1;
        end else if (live) begin
            if (nf) begin
                for (int i = 0; i < 2; i++) begin
                    if (m_new[i]) begin
                        m_act[i] = m_sh[i];
                        m_age[i] = 0;
                        m_new[i] = 1'b0;
                    end else begin
                        if (m_age[i] < 30) m_age[i]++;
                        if (m_age[i] >= 30) m_act[i] = OFFP;
                    end
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (vld[i] && rdy[i]) begin
                        if (good(pkts[i])) begin
                            m_sh[i]  = pkts[i];
                            m_new[i] = 1'b1;
                        end else if (m_rej < 255) begin
                            m_rej++;
                        end
                    end
                end
            end
        end
        prev_vld  = vld;
        prev_xfer = vld & rdy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_nf();
        nf = 1'b1;
        tick();
        nf = 1'b0;
        tick();
    endtask

    task automatic send(input int i, input sprite_pkt_t p);
        bit ok;
        ok      = 1'b0;
        pkts[i] = p;
        vld[i]  = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (rdy[i]) ok = 1'b1;
            tick();
        end
        vld[i] = 1'b0;
        chk("send_handshake", 69'(ok), 69'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "bench timeout");
    end

    logic [1:0] seq [6];
    sprite_pkt_t p1, p2, pedge, pa, pb;

    initial begin
        p1    = mk(100, 200, 180, 400, 190, 250);
        p2    = mk(300, 100, 350, 150, 320, 120);
        pedge = mk(959, 0, 959, 639, 0, 639);
        pa    = mk(10, 20, 30, 40, 50, 60);
        pb    = mk(500, 300, 600, 400, 550, 350);
        pkts  = '{OFFP, OFFP};

        // Reset and first frame
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 69'(rdy), 69'(0));
        chk("reset_stale", 69'(stl), 69'(2'b11));
        chk("reset_box_x", 69'(ppkt.box_x), 69'(960));
        tick();
        pulse_nf();
        @(negedge clk);
        chk("nf0_visible", 69'(vis), 69'(2'b00));
        chk("nf0_stale",   69'(stl), 69'(2'b11));
        chk("nf0_box_x",   69'(ppkt.box_x), 69'(960));
        chk("nf0_reject",  69'(rej), 69'(0));
        tick();

        // Player update is held until the frame boundary
        send(0, p1);
        @(negedge clk);
        chk("midframe_box_x", 69'(ppkt.box_x), 69'(960));
        tick();
        nf = 1'b1;
        @(negedge clk);
        chk("nf_cycle_box_x", 69'(ppkt.box_x), 69'(960));
        tick();
        nf = 1'b0;
        @(negedge clk);
        chk("commit_player", 69'(ppkt), 69'(mk(100, 200, 180, 400, 190, 250)));
        chk("commit_visible", 69'(vis), 69'(2'b01));
        chk("commit_stale",   69'(stl), 69'(2'b10));
        tick();

        // Rejected packets and counter saturation
        send(0, mk(100, 200, 50, 400, 190, 250));
        send(0, mk(100, 200, 180, 400, 960, 250));
        pulse_nf();
        @(negedge clk);
        chk("reject_two", 69'(rej), 69'(2));
        chk("reject_shadow_kept", 69'(ppkt), 69'(mk(100, 200, 180, 400, 190, 250)));
        tick();
        for (int k = 0; k < 300; k++) begin
            case (k % 3)
                0:       send(0, mk(100, 200, 99, 400, 190, 250));
                1:       send(0, mk(100, 200, 180, 640, 190, 250));
                default: send(0, mk(960, 200, 970, 400, 190, 250));
            endcase
        end
        @(negedge clk);
        chk("reject_saturate", 69'(rej), 69'(255));
        tick();

        // Staleness after 30 frames with no update
        send(0, p2);
        pulse_nf();
        for (int k = 1; k <= 30; k++) begin
            pulse_nf();
            if (k == 29) begin
                @(negedge clk);
                chk("stale_29", 69'(stl[0]), 69'(0));
                tick();
            end
        end
        @(negedge clk);
        chk("stale_30",         69'(stl[0]), 69'(1));
        chk("stale_30_visible", 69'(vis[0]), 69'(0));
        chk("stale_30_pkt",     69'(ppkt),   69'(OFFP));
        tick();
        send(0, pedge);
        pulse_nf();
        @(negedge clk);
        chk("restore_visible", 69'(vis[0]), 69'(1));
        chk("restore_pkt",     69'(ppkt),   69'(mk(959, 0, 959, 639, 0, 639)));
        tick();

        // Reset between accept and commit discards the shadow
        send(0, p1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        pulse_nf();
        @(negedge clk);
        chk("rst_discard_pkt",     69'(ppkt), 69'(OFFP));
        chk("rst_discard_visible", 69'(vis),  69'(2'b00));
        chk("rst_discard_reject",  69'(rej),  69'(0));
        tick();

        // Both requesters valid: alternating grants starting with player
        pkts[0] = pa;
        pkts[1] = pb;
        vld     = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seq[k] = rdy;
            tick();
        end
        vld = 2'b00;
        chk("rr_cycle0", 69'(seq[0]), 69'(2'b00));
        chk("rr_grant0", 69'(seq[1]), 69'(2'b01));
        chk("rr_grant1", 69'(seq[2]), 69'(2'b10));
        chk("rr_grant2", 69'(seq[3]), 69'(2'b01));
        chk("rr_grant3", 69'(seq[4]), 69'(2'b10));
        chk("rr_grant4", 69'(seq[5]), 69'(2'b01));
        tick();
        pulse_nf();
        @(negedge clk);
        chk("rr_both_visible", 69'(vis),  69'(2'b11));
        chk("rr_opponent_pkt", 69'(opkt), 69'(mk(500, 300, 600, 400, 550, 350)));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_frame_scheduler.md
Name: sprite_frame_scheduler

Overview:
- Arbitrates sprite-position updates from two requesters and buffers them so the display path sees coordinates that never change mid-frame.
- Requester 0 is the local player tracker; requester 1 is the opponent link receiver.
- Accepted packets land in shadow registers; on the new-frame pulse they commit to active registers that drive display_module's box/saber inputs.
- Also validates packets and flags requesters whose updates go stale.

Parameters:
- SCREEN_W, 960, playfield width; x coordinates must be < SCREEN_W.
- SCREEN_H, 640, playfield height; y coordinates must be < SCREEN_H.
- STALE_FRAMES, 30, frames without an accepted packet before a requester is marked stale.

Ports:
- clk_in  input  1  pixel clock.
- rst_in  input  1  synchronous, active-high reset.
- nf_in  input  1  new-frame pulse, one cycle wide.
- req_valid_in  input  2  per-requester packet valid; bit0 = player, bit1 = opponent.
- req_ready_out  output  2  per-requester accept.
- req_pkt_in  input  2x69  sprite_pkt_t per requester: box_x[11:0], box_y[10:0], box_xmax[11:0], box_ymax[10:0], saber_x[11:0], saber_y[10:0].
- player_pkt_out  output  69  active player sprite_pkt_t.
- opponent_pkt_out  output  69  active opponent sprite_pkt_t.
- visible_out  output  2  active sprite visible, per requester.
- stale_out  output  2  requester stale flag.
- reject_count_out  output  8  count of rejected packets, saturating.

Behaviour:
- Reset (any cycle, including mid-frame):
  - All shadow and active packets become OFFSCREEN_PKT: every x = SCREEN_W, every y = SCREEN_H.
  - visible_out = 0, stale_out = 2'b11, reject_count_out = 0, req_ready_out = 0.
  - Shadow dirty bits clear; frame-age counters = STALE_FRAMES.
  - Outputs are valid on the first cycle after rst_in deasserts.
- Ready:
  - req_ready_out is registered.
  - Both bits are forced low in any cycle where nf_in = 1, so acceptance never coincides with commit.
  - Otherwise ready is high only for the requester granted by the arbiter for that cycle.
- Handshake:
  - A transfer occurs when valid & ready are both high.
  - A requester holds its packet stable while valid is high and ready is low.
  - At most one transfer per cycle.
- Arbiter:
  - Round-robin, with a 1-bit last_grant register (reset value 1, so requester 0 wins first).
  - If both requesters are valid, grant goes to ~last_grant; if one is valid, that one is granted. last_grant updates only on a transfer.
  - States: IDLE (no valid), GRANT0, GRANT1. The state is computed from the registered valid inputs, so ready follows valid by 1 cycle.
  - A requester asserting valid continuously with the other idle is accepted every other cycle; its throughput is ≥1 packet per 2 cycles.
- Validation at transfer:
  - A packet is rejected if box_xmax < box_x, box_ymax < box_y, any x ≥ SCREEN_W, or any y ≥ SCREEN_H.
  - A rejected packet is still handshaken (ready consumed), but the shadow is unchanged and reject_count increments, saturating at 255.
  - A valid packet overwrites the requester's shadow and sets its dirty bit. The last valid packet within a frame wins.
- Commit on nf_in (single cycle), for each requester:
  - If dirty: active ← shadow, age ← 0, dirty ← 0.
  - Else: age ← min(age+1, STALE_FRAMES).
- Stale and visibility:
  - stale_out[i] = (age ≥ STALE_FRAMES), registered and updated in the commit cycle.
  - visible_out[i] = !stale_out[i].
  - A stale requester's active packet is replaced by OFFSCREEN_PKT at commit so nothing draws.
- Active packets and visible_out change only in the cycle after nf_in. They are constant at every other cycle.
- Age counter width is $clog2(STALE_FRAMES+1).

Decomposition:
- Package sprite_pkg holds:
  - sprite_pkt_t (packed struct, 69 bits).
  - OFFSCREEN_PKT localparam function of SCREEN_W/SCREEN_H.
  - coord widths X_W = 12, Y_W = 11.
  - pkt_ok() validation function.
- One sub-module, rr_arbiter2: 2-requester round-robin arbiter with registered grant; it is reused by other shared-resource controllers.
- Per-requester shadow/age logic is a generate loop, not a separate module.

Test Plan:
- Reset, then one nf_in → visible_out = 00, stale_out = 11, player_pkt_out.box_x = 960, reject_count_out = 0.
- Player sends box (100, 200, 180, 400) with saber (190, 250) mid-frame; outputs stay unchanged until nf_in, then update the cycle after. visible_out[0] = 1 and stale_out[0] = 0; opponent stays stale.
- Both requesters hold valid for 6 cycles → grants alternate 0, 1, 0, 1 (beginning with requester 0 after reset). No cycle has both ready bits high; no ready while nf_in = 1.
- Packet with box_xmax = 50 < box_x = 100, then packet with saber_x = 960 → both consumed, shadow unchanged, reject_count_out = 2. 300 more bad packets → saturates at 255.
- Player updates once, then sends nothing for 30 frames → stale_out[0] rises at the 30th nf_in after the last commit. visible_out[0] = 0 and player_pkt_out = OFFSCREEN_PKT. A new valid packet restores visibility at the next nf_in.
- Assert rst_in mid-frame, after an accept but before commit → the shadow is discarded and the next nf_in commits nothing (outputs remain OFFSCREEN_PKT).
